// File: rtl/mem_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_initiator
//  Description : Single-outstanding memory-port master. Serialises core
//                load/store requests onto a mem_read/mem_write/mem_wait
//                port, drops the first READ cycle's data as possibly stale,
//                and answers with an error if a read never completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_initiator #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_w,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_r,
  input  logic              mem_wait
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_READ  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_data_w, w_mem_data_w_nxt;
  logic              r_mem_write,  w_mem_write_nxt;
  logic              r_mem_read,   w_mem_read_nxt;
  logic              r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data,   w_rsp_data_nxt;
  logic              r_rsp_error,  w_rsp_error_nxt;
  logic              r_busy;

  logic w_accept;
  logic w_rd_done;
  logic w_timeout;
  logic w_rd_abort;

  assign req_ready = en && (r_state == c_IDLE);
  assign w_accept  = req_valid && req_ready;

  // The first READ cycle (wait_cnt==0) may carry data from an earlier read,
  // so completion is only allowed from the second cycle onward.
  assign w_rd_done  = (r_state == c_READ) && (r_wait_cnt != '0) && !mem_wait;
  // Completion has priority over a timeout firing in the same cycle.
  assign w_rd_abort = (r_state == c_READ) && w_timeout && !w_rd_done;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign w_timeout = (r_wait_cnt == c_TO_LAST);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // State register; en low freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = req_write ? c_WRITE : c_READ;
      c_WRITE: w_state_nxt = c_IDLE;
      c_READ:  if (w_rd_done || w_rd_abort) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Next values of the registered outputs and the read wait counter.
  always_comb begin
    w_mem_addr_nxt   = '0;
    w_mem_data_w_nxt = '0;
    w_mem_write_nxt  = 1'b0;
    w_mem_read_nxt   = 1'b0;
    w_wait_cnt_nxt   = '0;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_error_nxt  = r_rsp_error;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_mem_addr_nxt = req_addr;
          if (req_write) begin
            w_mem_write_nxt  = 1'b1;
            w_mem_data_w_nxt = req_wdata;
          end else begin
            w_mem_read_nxt = 1'b1;
          end
        end
      end
      c_WRITE: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = '0;
        w_rsp_error_nxt = 1'b0;
      end
      c_READ: begin
        if (w_rd_done) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = mem_data_r;
          w_rsp_error_nxt = 1'b0;
        end else if (w_rd_abort) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_error_nxt = 1'b1;
        end else begin
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = r_mem_addr;
          w_wait_cnt_nxt = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt
                                                     : r_wait_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers; all hold while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_mem_addr   <= '0;
      r_mem_data_w <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
      r_busy       <= 1'b0;
    end else if (en) begin
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_data_w <= w_mem_data_w_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_error  <= w_rsp_error_nxt;
      r_busy       <= (w_state_nxt != c_IDLE);
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_data_w = r_mem_data_w;
  assign mem_write  = r_mem_write;
  assign mem_read   = r_mem_read;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_error  = r_rsp_error;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_initiator
//  Description : Directed self-checking bench for mem_initiator with a small
//                registered-read memory responder and a programmable wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_w;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_data_r = '0;
  logic          mem_wait;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder: mem_wait stays high for the first wait_cfg READ cycles
  int            wait_cfg = 0;
  int            rd_cycles = 0;
  logic [DW-1:0] mem [0:255];

  assign mem_wait = mem_read && (rd_cycles < wait_cfg);

  always #5 clk = ~clk;

  // Memory model: registered read data, one-cycle write
  always @(posedge clk) begin
    if (en) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_data_w;
      if (mem_read)  mem_data_r <= mem[mem_addr[7:0]];
      rd_cycles <= mem_read ? rd_cycles + 1 : 0;
    end
  end

  mem_initiator #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .mem_addr(mem_addr), .mem_data_w(mem_data_w),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_data_r(mem_data_r), .mem_wait(mem_wait)
  );

  // Issue one request; returns at the sample point of cycle 1
  task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  // Observe cycles 1..ncyc of a load; ends at the sample point of cycle ncyc
  task automatic watch_load(input int ncyc, input logic [AW-1:0] a,
                            output int rsp_cyc, output int rsp_cnt,
                            output logic [DW-1:0] data, output logic err,
                            output int rd_cnt, output logic addr_ok);
    rsp_cyc = 0; rsp_cnt = 0; data = '0; err = 1'b0; rd_cnt = 0; addr_ok = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      if (mem_read) begin
        rd_cnt++;
        if (mem_addr !== a) addr_ok = 1'b0;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc == 0) begin rsp_cyc = c; data = rsp_data; err = rsp_error; end
      end
      if (c != ncyc) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_error, busy, mem_read, mem_write} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {rsp_valid, rsp_error, busy, mem_read, mem_write}); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_data_w !== '0) begin n_fail++; $display("FAIL reset_mem_data_w: got %h expected 0", mem_data_w); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_en1: got %b expected 1", req_ready); end
    en = 1'b0; #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_en0: got %b expected 0", req_ready); end
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    start_req(1'b1, 16'h0010, 32'hDEADBEEF);
    n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL store_mem_write: got %b expected 1", mem_write); end
    n_checks++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL store_mem_addr: got %h expected 0010", mem_addr); end
    n_checks++; if (mem_data_w !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_mem_data_w: got %h expected deadbeef", mem_data_w); end
    n_checks++; if ({busy, req_ready, rsp_valid, mem_read} !== 4'b1000) begin n_fail++;
      $display("FAIL store_c1_flags: got %b expected 1000", {busy, req_ready, rsp_valid, mem_read}); end
    @(negedge clk);
    n_checks++; if ({mem_write, rsp_valid, rsp_error, req_ready, busy} !== 5'b01010) begin n_fail++;
      $display("FAIL store_c2_flags: got %b expected 01010", {mem_write, rsp_valid, rsp_error, req_ready, busy}); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL store_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL store_addr_idle: got %h expected 0", mem_addr); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL store_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  // Also preloads 0x0020 with 0x1 for the stale-data test
  task automatic test_back_to_back();
    start_req(1'b1, 16'h0020, 32'h1);
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 2'b11) begin n_fail++;
      $display("FAIL b2b_rsp_and_ready: got %b expected 11", {rsp_valid, req_ready}); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0024; req_wdata = 32'h0000A5A5;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    n_checks++; if ({mem_write, rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL b2b_second_write: got %b expected 10", {mem_write, rsp_valid}); end
    n_checks++; if (mem_addr !== 16'h0024) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 0024", mem_addr); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_rsp: got %b expected 1", rsp_valid); end
  endtask

  // mem_wait high in READ cycles 1-4: three waits beyond the minimum, so 3+3=6
  task automatic test_load_wait();
    int rc, cnt, rd; logic [DW-1:0] d; logic e, aok;
    wait_cfg = 4;
    start_req(1'b0, 16'h0010, '0);
    watch_load(10, 16'h0010, rc, cnt, d, e, rd, aok);
    wait_cfg = 0;
    n_checks++; if (rc !== 6) begin n_fail++; $display("FAIL load_wait_latency: got %0d expected 6", rc); end
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL load_wait_rsp_count: got %0d expected 1", cnt); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_wait_data: got %h expected deadbeef", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL load_wait_error: got %b expected 0", e); end
    n_checks++; if (rd !== 5) begin n_fail++; $display("FAIL load_wait_read_cycles: got %0d expected 5", rd); end
    n_checks++; if (aok !== 1'b1) begin n_fail++; $display("FAIL load_wait_addr_stable: got %b expected 1", aok); end
  endtask

  task automatic test_stale();
    int rc, cnt, rd; logic [DW-1:0] d; logic e, aok;
    start_req(1'b0, 16'h0020, '0);
    watch_load(5, 16'h0020, rc, cnt, d, e, rd, aok);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL stale_first_data: got %h expected 1", d); end
    n_checks++; if (rc !== 3) begin n_fail++; $display("FAIL stale_first_latency: got %0d expected 3", rc); end
    start_req(1'b1, 16'h0020, 32'h2);
    @(negedge clk);
    start_req(1'b0, 16'h0020, '0);
    watch_load(5, 16'h0020, rc, cnt, d, e, rd, aok);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL stale_second_data: got %h expected 2", d); end
    n_checks++; if (rc !== 3) begin n_fail++; $display("FAIL stale_second_latency: got %0d expected 3", rc); end
  endtask

  task automatic test_timeout();
    int rc, cnt, rd; logic [DW-1:0] d; logic e, aok;
    wait_cfg = 1000;
    start_req(1'b0, 16'h0030, '0);
    watch_load(12, 16'h0030, rc, cnt, d, e, rd, aok);
    wait_cfg = 0;
    n_checks++; if (rd !== 8) begin n_fail++; $display("FAIL timeout_read_cycles: got %0d expected 8", rd); end
    n_checks++; if (rc !== 9) begin n_fail++; $display("FAIL timeout_rsp_cycle: got %0d expected 9", rc); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b expected 1", e); end
    n_checks++; if (d !== '0) begin n_fail++; $display("FAIL timeout_data: got %h expected 0", d); end
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL timeout_rsp_count: got %0d expected 1", cnt); end
    n_checks++; if ({busy, req_ready} !== 2'b01) begin n_fail++;
      $display("FAIL timeout_idle: got %b expected 01", {busy, req_ready}); end
  endtask

  task automatic test_en_freeze();
    logic held_ok;
    start_req(1'b0, 16'h0010, '0);
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL freeze_read_start: got %b expected 1", mem_read); end
    en = 1'b0;
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_read !== 1'b1 || mem_addr !== 16'h0010 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1)
        held_ok = 1'b0;
    end
    n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL freeze_hold: got %b expected 1", held_ok); end
    en = 1'b1;
    // wait_cnt was frozen at 0, so one more non-completing cycle follows
    @(negedge clk);
    n_checks++; if ({mem_read, rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL freeze_resume_c1: got %b expected 10", {mem_read, rsp_valid}); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL freeze_rsp: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL freeze_data: got %h expected deadbeef", rsp_data); end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 2'b10) begin n_fail++;
      $display("FAIL freeze_rsp_held: got %b expected 10", {rsp_valid, req_ready}); end
    en = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL freeze_rsp_clear: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    wait_cfg = 1000;
    start_req(1'b0, 16'h0010, '0);
    @(negedge clk);
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_read_before: got %b expected 1", mem_read); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_read_async: got %b expected 0", mem_read); end
    n_checks++; if ({busy, rsp_valid, rsp_error, mem_write} !== 4'b0) begin n_fail++;
      $display("FAIL rstmid_flags: got %b expected 0000", {busy, rsp_valid, rsp_error, mem_write}); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL rstmid_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rstmid_mem_addr: got %h expected 0", mem_addr); end
    wait_cfg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d expected 0", pulses); end
    start_req(1'b1, 16'h0040, 32'h55);
    n_checks++; if ({mem_write, mem_addr} !== {1'b1, 16'h0040}) begin n_fail++;
      $display("FAIL rstmid_new_write: got %b/%h expected 1/0040", mem_write, mem_addr); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_rsp: got %b expected 1", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_back_to_back();
    test_load_wait();
    test_stale();
    test_timeout();
    test_en_freeze();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
